word_serializer: RTL and testbench

Parallel-to-serial stage downstream of the bit-order reverser. It accepts a 2**N-bit word over a valid/ready handshake and shifts it out one bit per enabled cycle, LSB-first or MSB-first. It flags the first and last bit of each frame. Back-to-back words stream without a gap bit, so the reverser output can be driven onto a single-wire link.

---
 rtl/word_serializer.sv | 91 +++++++++
 tb/tb_word_serializer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/word_serializer.sv
// word_serializer: parallel-to-serial stage. Accepts a 2**N-bit word over a
// valid/ready handshake and shifts it out one bit per enabled cycle, LSB-first
// or MSB-first, with frame_start/frame_last markers. A new word can be taken
// in the same cycle the previous word's last bit is consumed, so consecutive
// frames stream with no gap bit.
module word_serializer #(
    parameter int N = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2**N-1:0]   data_in,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic              msb_first,
    input  logic              ser_en,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              frame_start,
    output logic              frame_last
);

    localparam int W = 2**N;
    // Bit index W-1 is all ones in an N-bit counter.
    localparam logic [N-1:0] CNT_LAST = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   sreg_q, sreg_d;
    logic [N-1:0]   cnt_q, cnt_d;
    logic           dir_q, dir_d;

    logic           on_last;
    logic           accept;

    assign on_last = (state_q == SHIFT) && (cnt_q == CNT_LAST);

    // Ready when idle, or when the last bit leaves this cycle; this is the
    // only output with a combinational dependence on an input (ser_en).
    assign load_ready = !rst && ((state_q == IDLE) || (on_last && ser_en));
    assign accept     = load_valid && load_ready;

    // Serial outputs decode registered state only; data_in never reaches them.
    assign ser_valid   = (state_q == SHIFT);
    assign ser_out     = (state_q == SHIFT) ? (dir_q ? sreg_q[W-1] : sreg_q[0]) : 1'b0;
    assign frame_start = (state_q == SHIFT) && (cnt_q == '0);
    assign frame_last  = on_last;

    // Next-state: load wins, then shift/finish on ser_en, otherwise hold.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        if (accept) begin
            state_d = SHIFT;
            sreg_d  = data_in;
            cnt_d   = '0;
            dir_d   = msb_first;
        end else if (state_q == SHIFT && ser_en) begin
            if (cnt_q == CNT_LAST) begin
                // Last bit consumed with no follow-on word.
                state_d = IDLE;
                sreg_d  = '0;
                cnt_d   = '0;
            end else begin
                cnt_d  = cnt_q + 1'b1;
                sreg_d = dir_q ? (sreg_q << 1) : (sreg_q >> 1);
            end
        end
    end

    // State registers with synchronous reset; reset also drops any accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Directed self-checking bench for word_serializer (N=3, W=8).
// Inputs change just after the falling edge; outputs are checked 1ns later,
// well away from the rising edge that updates state.
module tb_word_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       load_valid;
    logic       load_ready;
    logic       msb_first;
    logic       ser_en;
    logic       ser_out;
    logic       ser_valid;
    logic       frame_start;
    logic       frame_last;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    word_serializer #(.N(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .msb_first   (msb_first),
        .ser_en      (ser_en),
        .ser_out     (ser_out),
        .ser_valid   (ser_valid),
        .frame_start (frame_start),
        .frame_last  (frame_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one full cycle, landing just after the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a word and take the accept edge; caller is then in cycle 1.
    task automatic load(input logic [7:0] d, input logic msb);
        load_valid = 1'b1;
        data_in    = d;
        msb_first  = msb;
        #1 chk("load_ready_on_load", load_ready, 1'b1);
        tick();
        load_valid = 1'b0;
        data_in    = 8'h00;
    endtask

    // exp holds the serial bits with cycle 1 in bit 7 and cycle 8 in bit 0.
    task automatic run_frame(input string tag, input logic [7:0] exp, input bit toggle_msb);
        ser_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (toggle_msb) msb_first = ~msb_first;
            #1;
            chk({tag, "_bit"},   ser_out,     exp[7-i]);
            chk({tag, "_valid"}, ser_valid,   1'b1);
            chk({tag, "_start"}, frame_start, (i == 0));
            chk({tag, "_last"},  frame_last,  (i == 7));
            tick();
        end
        #1;
        chk({tag, "_idle_valid"}, ser_valid,  1'b0);
        chk({tag, "_idle_ready"}, load_ready, 1'b1);
    endtask

    initial begin
        logic [7:0] exp;
        rst = 1'b1; data_in = 8'h00; load_valid = 1'b0; msb_first = 1'b0; ser_en = 1'b0;
        @(negedge clk);
        tick();

        // Reset state
        #1;
        chk("rst_ready",  load_ready,  1'b0);
        chk("rst_valid",  ser_valid,   1'b0);
        chk("rst_out",    ser_out,     1'b0);
        chk("rst_start",  frame_start, 1'b0);
        chk("rst_last",   frame_last,  1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_ready", load_ready, 1'b1);

        // 8'hA5 LSB-first: 1,0,1,0,0,1,0,1
        ser_en = 1'b1;
        load(8'hA5, 1'b0);
        run_frame("a5_lsb", 8'b10100101, 1'b0);

        // 8'h96 MSB-first with msb_first toggling mid-frame: 1,0,0,1,0,1,1,0
        load(8'h96, 1'b1);
        run_frame("96_msb", 8'b10010110, 1'b1);
        msb_first = 1'b0;

        // 8'hA5 LSB-first, ser_en 0,1,0,1,...: each bit held two cycles
        exp = 8'b10100101;
        load(8'hA5, 1'b0);
        for (int c = 0; c < 16; c++) begin
            ser_en = c[0];
            #1;
            chk("stall_bit",   ser_out,     exp[7-c/2]);
            chk("stall_valid", ser_valid,   1'b1);
            chk("stall_start", frame_start, (c/2 == 0));
            chk("stall_last",  frame_last,  (c/2 == 7));
            chk("stall_ready", load_ready,  (c == 15));
            tick();
        end
        #1 chk("stall_end_valid", ser_valid, 1'b0);

        // Back-to-back 8'hFF then 8'h00 with load_valid held
        ser_en     = 1'b1;
        load_valid = 1'b1;
        data_in    = 8'hFF;
        msb_first  = 1'b0;
        #1 chk("b2b_ready0", load_ready, 1'b1);
        tick();
        data_in = 8'h00;
        for (int c = 0; c < 16; c++) begin
            if (c == 8) load_valid = 1'b0;
            #1;
            chk("b2b_bit",   ser_out,     (c < 8));
            chk("b2b_valid", ser_valid,   1'b1);
            chk("b2b_start", frame_start, (c == 0 || c == 8));
            if (c < 15) chk("b2b_ready", load_ready, (c == 7));
            tick();
        end
        #1 chk("b2b_end_valid", ser_valid, 1'b0);

        // Reset while bit 3 of 8'hA5 is out
        load(8'hA5, 1'b0);
        for (int c = 0; c < 3; c++) tick();
        #1 chk("mid_bit3", ser_out, 1'b0);
        rst = 1'b1;
        #1 chk("mid_rst_ready", load_ready, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("abort_valid", ser_valid,   1'b0);
        chk("abort_out",   ser_out,     1'b0);
        chk("abort_ready", load_ready,  1'b1);
        chk("abort_last",  frame_last,  1'b0);
        load(8'h01, 1'b0);
        run_frame("restart_01", 8'b10000000, 1'b0);

        // Load request during a frame is held off until the last bit
        exp = 8'b00111100;   // 8'h3C LSB-first
        load(8'hA5, 1'b0);
        for (int c = 0; c < 8; c++) begin
            if (c == 3) begin load_valid = 1'b1; data_in = 8'h3C; end
            #1;
            chk("hold_a5_bit", ser_out, 8'hA5 >> c & 1);
            if (c >= 3) chk("hold_ready", load_ready, (c == 7));
            tick();
        end
        load_valid = 1'b0;
        data_in    = 8'h00;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("hold_3c_bit",   ser_out,     exp[7-c]);
            chk("hold_3c_start", frame_start, (c == 0));
            tick();
        end

        // Reset overrides an accept in the same cycle
        load_valid = 1'b1;
        data_in    = 8'hFF;
        rst        = 1'b1;
        tick();
        rst        = 1'b0;
        load_valid = 1'b0;
        #1 chk("rst_over_accept", ser_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
